// File: rtl/traffic_phase_sequencer_if.sv
// Sensor inputs and timing/lamp outputs of the traffic phase sequencer.
// The master modport is the sequencer; the slave modport is its consumer/driver side.
interface traffic_phase_sequencer_if;
  logic       sensor_ns;
  logic       sensor_ew;
  logic       sec_tick;
  logic [5:0] sec_count;
  logic [2:0] phase;
  logic [2:0] ns_light;
  logic [2:0] ew_light;

  modport master (
    input  sensor_ns, sensor_ew,
    output sec_tick, sec_count, phase, ns_light, ew_light
  );

  modport slave (
    output sensor_ns, sensor_ew,
    input  sec_tick, sec_count, phase, ns_light, ew_light
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// One-second prescaler, per-phase seconds counter and NS/EW phase ring with
// demand-latched sensors; lamps are decoded from the phase register.
module traffic_phase_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int MIN_GREEN   = 24,
  parameter int MAX_GREEN   = 60,
  parameter int YELLOW_SEC  = 3,
  parameter int ALL_RED_SEC = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  traffic_phase_sequencer_if.master   bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [5:0]    MIN_G_LAST = 6'(MIN_GREEN - 1);
  localparam logic [5:0]    MAX_G_LAST = 6'(MAX_GREEN - 1);
  localparam logic [5:0]    Y_LAST     = 6'(YELLOW_SEC - 1);
  localparam logic [5:0]    AR_LAST    = 6'(ALL_RED_SEC - 1);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5
  } phase_e;

  phase_e        state_r;
  phase_e        next_state_s;
  logic [PW-1:0] presc_r;
  logic [5:0]    sec_count_r;
  logic          dem_ns_r;
  logic          dem_ew_r;
  logic          tick_s;
  logic          advance_s;
  logic [2:0]    ns_light_s;
  logic [2:0]    ew_light_s;

  assign tick_s = (presc_r == PRE_LAST);

  // Exit condition and successor for the current phase; unused codes fall to AR_B at once.
  always_comb begin
    next_state_s = state_r;
    advance_s    = 1'b0;
    case (state_r)
      NS_G: begin
        next_state_s = NS_Y;
        advance_s    = tick_s && (((sec_count_r >= MIN_G_LAST) && dem_ew_r) ||
                                  (sec_count_r == MAX_G_LAST));
      end
      NS_Y: begin
        next_state_s = AR_A;
        advance_s    = tick_s && (sec_count_r == Y_LAST);
      end
      AR_A: begin
        next_state_s = EW_G;
        advance_s    = tick_s && (sec_count_r == AR_LAST);
      end
      EW_G: begin
        next_state_s = EW_Y;
        advance_s    = tick_s && (((sec_count_r >= MIN_G_LAST) && dem_ns_r) ||
                                  (sec_count_r == MAX_G_LAST));
      end
      EW_Y: begin
        next_state_s = AR_B;
        advance_s    = tick_s && (sec_count_r == Y_LAST);
      end
      AR_B: begin
        next_state_s = NS_G;
        advance_s    = tick_s && (sec_count_r == AR_LAST);
      end
      default: begin
        next_state_s = AR_B;
        advance_s    = 1'b1;
      end
    endcase
  end

  // Lamp decode: anything other than a green/yellow of one direction is all-red.
  always_comb begin
    ns_light_s = 3'b100;
    ew_light_s = 3'b100;
    case (state_r)
      NS_G: begin
        ns_light_s = 3'b001;
        ew_light_s = 3'b100;
      end
      NS_Y: begin
        ns_light_s = 3'b010;
        ew_light_s = 3'b100;
      end
      EW_G: begin
        ns_light_s = 3'b100;
        ew_light_s = 3'b001;
      end
      EW_Y: begin
        ns_light_s = 3'b100;
        ew_light_s = 3'b010;
      end
      default: begin
        ns_light_s = 3'b100;
        ew_light_s = 3'b100;
      end
    endcase
  end

  // Prescaler, seconds counter, phase register and demand latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r     <= '0;
      sec_count_r <= 6'd0;
      state_r     <= AR_B;
      dem_ns_r    <= 1'b0;
      dem_ew_r    <= 1'b0;
    end else begin
      presc_r <= tick_s ? '0 : (presc_r + PRE_ONE);
      if (advance_s) begin
        state_r     <= next_state_s;
        sec_count_r <= 6'd0;
      end else if (tick_s) begin
        sec_count_r <= sec_count_r + 6'd1;
      end
      // Clearing on entry to the own green beats a same-edge sensor set.
      dem_ns_r <= (advance_s && (next_state_s == NS_G)) ? 1'b0 : (dem_ns_r | bus.sensor_ns);
      dem_ew_r <= (advance_s && (next_state_s == EW_G)) ? 1'b0 : (dem_ew_r | bus.sensor_ew);
    end
  end

  assign bus.sec_tick  = tick_s;
  assign bus.sec_count = sec_count_r;
  assign bus.phase     = state_r;
  assign bus.ns_light  = ns_light_s;
  assign bus.ew_light  = ew_light_s;

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Timing-and-sequencing stage of the traffic light controller. It divides the system clock into a one-second tick and counts elapsed seconds within the current phase. The six-bit seconds count is the `din` bus consumed by the green, yellow and red comparators. It also runs the NS/EW phase state machine with demand-latched sensors and drives the one-hot lamp outputs.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per second tick; must be ≥ 2.
- `MIN_GREEN`, 24: minimum green seconds; must be ≥ 1.
- `MAX_GREEN`, 60: maximum green seconds; MIN_GREEN ≤ MAX_GREEN ≤ 63.
- `YELLOW_SEC`, 3: yellow seconds; must be ≥ 1.
- `ALL_RED_SEC`, 1: all-red clearance seconds; must be ≥ 1.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sensor_ns`  in  1: vehicle present on the NS approach; synchronous to `clk`.
- `sensor_ew`  in  1: vehicle present on the EW approach; synchronous to `clk`.
- `sec_tick`  out  1: one-cycle pulse, once per second.
- `sec_count`  out  6: whole seconds elapsed in the current phase (the comparator `din`).
- `phase`  out  3: state encoding. 0 = NS_G, 1 = NS_Y, 2 = AR_A, 3 = EW_G, 4 = EW_Y, 5 = AR_B.
- `ns_light`  out  3: one-hot lamp, {red, yellow, green}.
- `ew_light`  out  3: one-hot lamp, {red, yellow, green}.

## Operation
- **Prescaler.** Counts 0 to TICK_DIV−1 and wraps; it is free-running and independent of phase. `sec_tick` = (prescaler == TICK_DIV−1), decoded from the register.
- **sec_count.** Increments on each edge where `sec_tick` = 1. It is cleared to 0 on the same edge as any phase change. It never wraps, because MAX_GREEN ≤ 63 bounds it.
- **Phase sequence.** Fixed ring: NS_G → NS_Y → AR_A → EW_G → EW_Y → AR_B → NS_G.
- **Fixed-length phases.** At an edge with `sec_tick` = 1:
  - NS_Y and EW_Y exit when sec_count == YELLOW_SEC−1.
  - AR_A and AR_B exit when sec_count == ALL_RED_SEC−1.
- **Green phases.** At an edge with `sec_tick` = 1, green exits when either condition holds:
  - sec_count ≥ MIN_GREEN−1 and the opposing demand latch is set; or
  - sec_count == MAX_GREEN−1, regardless of demand.
- **Demand latches.**
  - `dem_ns` is set on any cycle with `sensor_ns` = 1. `dem_ew` is set likewise from `sensor_ew`.
  - A latch is cleared on the edge entering its own direction's green.
  - If the sensor is high on that same edge, clear wins. The latch re-sets on the next cycle if the sensor is still high.
  - The latch for the direction currently green still sets normally while that direction is green.
- **Lamps.** Combinational decode of the state register.
  - NS_G: ns = 001, ew = 100.
  - NS_Y: ns = 010, ew = 100.
  - EW_G: ns = 100, ew = 001.
  - EW_Y: ns = 100, ew = 010.
  - AR_A and AR_B: ns = 100, ew = 100.
  - An unused encoding (6, 7) drives both lamps 100 and goes to AR_B on the next edge.
- **Safety invariant.** Both directions are never non-red at the same time.

## Timing
- **Reset.** While `rst` = 1 at an edge:
  - prescaler = 0, sec_count = 0, phase = AR_B (5), dem_ns = dem_ew = 0.
  - sec_tick = 0, ns_light = ew_light = 100.
- **Reset mid-phase.** Asserting `rst` during any phase aborts it immediately at that edge; no partial yellow is completed.
- **First tick.** `sec_tick` is first high during the TICK_DIV-th cycle after reset release. It then repeats every TICK_DIV cycles.
- **Phase duration.** A phase of N seconds lasts exactly N × TICK_DIV cycles. The exception is the first AR_B after reset, which also lasts exactly ALL_RED_SEC × TICK_DIV cycles because the prescaler is reset too.
- **Transition latency.** Phase, lamps and sec_count = 0 all update on the edge that consumes the qualifying tick, with no extra latency.
- **Demand timing.** Demand arriving during the final tick cycle of a green that has reached MIN_GREEN−1 does not cause exit on that tick. The latch is not yet set, so the earliest exit is one second later.
- **Cap.** sec_count never exceeds max(MAX_GREEN, YELLOW_SEC, ALL_RED_SEC) − 1.

## Test plan
All scenarios use TICK_DIV = 4 and default MIN_GREEN, MAX_GREEN, YELLOW_SEC and ALL_RED_SEC unless stated.

1. **Reset and startup.** Pulse `rst`, then release.
   - Lamps 100/100 and phase = 5 immediately.
   - `sec_tick` is first high in cycle 4.
   - Phase becomes NS_G (0) at the 4th edge after release, with sec_count = 0.
2. **Demand-driven green exit.** Hold `sensor_ew` = 1 from startup.
   - NS_G lasts 24 s = 96 cycles, then NS_Y for 12 cycles, then AR_A for 4 cycles, then EW_G.
   - dem_ew clears on entering EW_G.
3. **No demand.** Keep both sensors at 0.
   - NS_G lasts 60 s = 240 cycles; sec_count reaches 59, then 0.
   - Full cycle: 60 + 3 + 1 + 60 + 3 + 1 s.
4. **Late demand.** Pulse `sensor_ew` for one cycle at NS_G second 40.
   - NS_G exits at the tick where sec_count = 40, so the phase totals 41 s.
   - `sensor_ns` pulses during NS_G change nothing.
5. **Reset mid-yellow.** Assert `rst` for one cycle during EW_Y with sec_count = 1.
   - Phase = 5, lamps 100/100, sec_count = 0 and both latches = 0 on that edge.
   - Sequence then restarts as in scenario 1.
6. **Safety invariant.** Run 10,000 cycles of random sensors and random resets.
   - Assert ns_light or ew_light equals 100 on every cycle.
   - Assert the lamps are always one-hot.
   - Assert sec_count ≤ 59.
